rtlfuzz_dromajo: RTL and testbench

- Commit-trace monitor attached to the core's writeback/trace port in the RTL-fuzzing testbench.
- Samples every retired-instruction record (pc, instruction, writeback data, side-info, trap info) and keeps commit and trap statistics.
- Raises a sticky `finish` when the program reaches a defined end condition; the testbench then stops with PASSED.
- The UART sink (tty) is a separate block and is not part of this spec.

---
 rtl/rtlfuzz_dromajo.sv | 119 +++++++++++
 tb/tb_rtlfuzz_dromajo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rtlfuzz_dromajo.sv
// Commit-trace monitor for the RTL-fuzzing harness: counts retired instructions
// and traps for one hart and raises a sticky finish on self-loop, hang or commit budget.
module rtlfuzz_dromajo #(
   parameter int XLEN        = 64,
   parameter int HARTID_W    = 1,
   parameter int MON_HART    = 0,
   parameter int LOOP_LIMIT  = 16,
   parameter int MAX_COMMITS = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                valid,
   input  logic [HARTID_W-1:0] hartid,
   input  logic [XLEN-1:0]     pc,
   input  logic [31:0]         inst,
   input  logic [XLEN-1:0]     wdata,
   input  logic [6:0]          mstatus,
   input  logic                int_xcpt,
   input  logic [XLEN-1:0]     cause,
   output logic                finish,
   output logic [63:0]         commit_count,
   output logic [31:0]         trap_count,
   output logic [XLEN-1:0]     last_pc,
   output logic [XLEN-1:0]     last_wdata,
   output logic [6:0]          last_info
);

   localparam int                LOOP_W       = $clog2(LOOP_LIMIT + 1);
   localparam logic [LOOP_W-1:0] LOOP_MAX     = LOOP_W'(LOOP_LIMIT);
   localparam logic [63:0]       COMMIT_LIMIT = 64'(MAX_COMMITS);
   localparam logic [31:0]       SELF_LOOP    = 32'h0000_006f;

   logic                finish_q,  finish_d;
   logic [63:0]         commit_q,  commit_d;
   logic [31:0]         trap_q,    trap_d;
   logic [XLEN-1:0]     lpc_q,     lpc_d;
   logic [XLEN-1:0]     lwdata_q,  lwdata_d;
   logic [6:0]          linfo_q,   linfo_d;
   logic [LOOP_W-1:0]   loop_q,    loop_d;
   logic [XLEN-1:0]     loop_pc_q, loop_pc_d;

   logic accept_s;
   logic same_pc_s;
   logic unused_cause_s;

   // Trap class (cause MSB) does not influence any statistic.
   assign unused_cause_s = ^cause;

   assign accept_s  = valid && (hartid == HARTID_W'(MON_HART)) && !finish_q;
   assign same_pc_s = (pc == loop_pc_q) && (commit_q != 64'd0);

   // Next-state for counters, last-record capture, hang detector and finish.
   always_comb begin
      finish_d  = finish_q;
      commit_d  = commit_q;
      trap_d    = trap_q;
      lpc_d     = lpc_q;
      lwdata_d  = lwdata_q;
      linfo_d   = linfo_q;
      loop_d    = loop_q;
      loop_pc_d = loop_pc_q;
      if (accept_s) begin
         if (int_xcpt) begin
            trap_d = (trap_q == 32'hFFFF_FFFF) ? trap_q : trap_q + 32'd1;
            loop_d = {LOOP_W{1'b0}};
         end else begin
            commit_d = commit_q + 64'd1;
            lpc_d    = pc;
            lwdata_d = wdata;
            linfo_d  = mstatus;
            if (same_pc_s) begin
               loop_d = (loop_q >= LOOP_MAX) ? LOOP_MAX : loop_q + LOOP_W'(1);
            end else begin
               loop_d    = LOOP_W'(1);
               loop_pc_d = pc;
            end
            if ((inst == SELF_LOOP) || (loop_d >= LOOP_MAX) ||
                ((COMMIT_LIMIT != 64'd0) && (commit_d == COMMIT_LIMIT))) begin
               finish_d = 1'b1;
            end else begin
               finish_d = finish_q;
            end
         end
      end else begin
         finish_d = finish_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         finish_q  <= 1'b0;
         commit_q  <= 64'd0;
         trap_q    <= 32'd0;
         lpc_q     <= {XLEN{1'b0}};
         lwdata_q  <= {XLEN{1'b0}};
         linfo_q   <= 7'd0;
         loop_q    <= {LOOP_W{1'b0}};
         loop_pc_q <= {XLEN{1'b0}};
      end else begin
         finish_q  <= finish_d;
         commit_q  <= commit_d;
         trap_q    <= trap_d;
         lpc_q     <= lpc_d;
         lwdata_q  <= lwdata_d;
         linfo_q   <= linfo_d;
         loop_q    <= loop_d;
         loop_pc_q <= loop_pc_d;
      end
   end

   assign finish       = finish_q;
   assign commit_count = commit_q;
   assign trap_count   = trap_q;
   assign last_pc      = lpc_q;
   assign last_wdata   = lwdata_q;
   assign last_info    = linfo_q;

endmodule

// File: tb/tb_rtlfuzz_dromajo.sv
// Directed plus randomized bench for rtlfuzz_dromajo; two instances (no commit
// budget and MAX_COMMITS=3) are checked against a behavioural model each cycle.
module tb_rtlfuzz_dromajo;

   localparam int LIM = 16;

   logic        clk = 1'b0;
   logic        reset, valid, int_xcpt;
   logic [0:0]  hartid;
   logic [63:0] pc, wdata, cause;
   logic [31:0] inst;
   logic [6:0]  mstatus;

   logic        fin   [2];
   logic [63:0] cc    [2];
   logic [31:0] tc    [2];
   logic [63:0] lpc   [2];
   logic [63:0] lwd   [2];
   logic [6:0]  linfo [2];

   int vectors    = 0;
   int miscompares = 0;

   // Reference state per instance
   int          max_c   [2] = '{0, 3};
   logic        m_fin   [2];
   logic [63:0] m_commit[2];
   logic [31:0] m_trap  [2];
   logic [63:0] m_pc    [2];
   logic [63:0] m_wd    [2];
   logic [6:0]  m_info  [2];
   int          m_run   [2];
   logic [63:0] m_rpc   [2];

   always #5 clk = ~clk;

   rtlfuzz_dromajo u_dut0 (
      .clock(clk), .reset(reset), .valid(valid), .hartid(hartid), .pc(pc),
      .inst(inst), .wdata(wdata), .mstatus(mstatus), .int_xcpt(int_xcpt),
      .cause(cause), .finish(fin[0]), .commit_count(cc[0]), .trap_count(tc[0]),
      .last_pc(lpc[0]), .last_wdata(lwd[0]), .last_info(linfo[0]));

   rtlfuzz_dromajo #(.MAX_COMMITS(3)) u_dut1 (
      .clock(clk), .reset(reset), .valid(valid), .hartid(hartid), .pc(pc),
      .inst(inst), .wdata(wdata), .mstatus(mstatus), .int_xcpt(int_xcpt),
      .cause(cause), .finish(fin[1]), .commit_count(cc[1]), .trap_count(tc[1]),
      .last_pc(lpc[1]), .last_wdata(lwd[1]), .last_info(linfo[1]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_fin[k] = 1'b0; m_commit[k] = 64'd0; m_trap[k] = 32'd0;
         m_pc[k] = 64'd0; m_wd[k] = 64'd0; m_info[k] = 7'd0;
         m_run[k] = 0;    m_rpc[k] = 64'd0;
      end
   endtask

   // Spec-level effect of one clock edge on the observable statistics.
   task automatic model_edge();
      bit same;
      if (reset) begin
         model_reset();
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (valid && hartid == 1'b0 && !m_fin[k]) begin
               if (int_xcpt) begin
                  if (m_trap[k] != 32'hFFFF_FFFF) m_trap[k] = m_trap[k] + 32'd1;
                  m_run[k] = 0;
               end else begin
                  same = (pc == m_rpc[k]) && (m_commit[k] != 64'd0);
                  m_commit[k] = m_commit[k] + 64'd1;
                  m_pc[k] = pc; m_wd[k] = wdata; m_info[k] = mstatus;
                  if (same) m_run[k] = (m_run[k] + 1 > LIM) ? LIM : m_run[k] + 1;
                  else begin m_run[k] = 1; m_rpc[k] = pc; end
                  if (inst == 32'h0000_006f || m_run[k] >= LIM ||
                      (max_c[k] != 0 && m_commit[k] == 64'(max_c[k])))
                     m_fin[k] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s.finish%0d", tag, k), 64'(fin[k]), 64'(m_fin[k]));
         chk($sformatf("%s.commit%0d", tag, k), cc[k], m_commit[k]);
         chk($sformatf("%s.trap%0d", tag, k), 64'(tc[k]), 64'(m_trap[k]));
         chk($sformatf("%s.last_pc%0d", tag, k), lpc[k], m_pc[k]);
         chk($sformatf("%s.last_wdata%0d", tag, k), lwd[k], m_wd[k]);
         chk($sformatf("%s.last_info%0d", tag, k), 64'(linfo[k]), 64'(m_info[k]));
      end
   endtask

   task automatic step(input string tag, input logic r, input logic v, input logic h,
                       input logic [63:0] p, input logic [31:0] i, input logic [63:0] w,
                       input logic x, input logic [63:0] c);
      reset = r; valid = v; hartid = h; pc = p; inst = i; wdata = w;
      mstatus = 7'($urandom); int_xcpt = x; cause = c;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic retire(input string tag, input logic [63:0] p, input logic [31:0] i,
                         input logic [63:0] w);
      step(tag, 1'b0, 1'b1, 1'b0, p, i, w, 1'b0, 64'd0);
   endtask

   initial begin
      logic [63:0] cur;
      reset = 1'b1; valid = 1'b0; hartid = 1'b0; pc = 64'd0; inst = 32'd0;
      wdata = 64'd0; mstatus = 7'd0; int_xcpt = 1'b0; cause = 64'd0;
      model_reset();

      // Reset held with random traffic
      for (int n = 0; n < 3; n++)
         step("rst", 1'b1, 1'b1, 1'($urandom), {$urandom, $urandom},
              32'h0000_006f, {$urandom, $urandom}, 1'($urandom), 64'd0);
      step("idle", 1'b0, 1'b0, 1'b0, 64'h8000_0000, 32'h13, 64'd0, 1'b0, 64'd0);
      chk("after_reset.commit", cc[0], 64'd0);

      for (int n = 0; n < 5; n++)
         retire("seq", 64'h8000_0000 + 64'(4 * n), 32'h13, 64'h11 + 64'(n));
      chk("seq.commit5", cc[0], 64'd5);
      chk("seq.last_pc", lpc[0], 64'h8000_0010);
      chk("seq.last_wdata", lwd[0], 64'h15);
      chk("seq.finish0", 64'(fin[0]), 64'd0);
      chk("max3.finish", 64'(fin[1]), 64'd1);
      chk("max3.commit", cc[1], 64'd3);

      step("trap", 1'b0, 1'b1, 1'b0, 64'h8000_0014, 32'h13, 64'd0, 1'b1, 64'h8000_0000_0000_0007);
      chk("trap.count", 64'(tc[0]), 64'd1);
      chk("trap.commit", cc[0], 64'd5);
      step("hart1", 1'b0, 1'b1, 1'b1, 64'h8000_0300, 32'h13, 64'hdead, 1'b0, 64'd0);
      chk("hart1.commit", cc[0], 64'd5);

      retire("jal", 64'h8000_0100, 32'h0000_006f, 64'h99);
      chk("jal.finish", 64'(fin[0]), 64'd1);
      chk("jal.commit", cc[0], 64'd6);
      retire("frozen", 64'h8000_0104, 32'h13, 64'h77);
      chk("frozen.commit", cc[0], 64'd6);

      step("rstpulse", 1'b1, 1'b0, 1'b0, 64'd0, 32'h13, 64'd0, 1'b0, 64'd0);
      chk("rstpulse.finish", 64'(fin[0]), 64'd0);
      chk("rstpulse.commit", cc[0], 64'd0);

      // Hang detection broken by a trap
      for (int n = 0; n < 10; n++) retire("loopA", 64'h8000_0200, 32'h13, 64'(n));
      step("loopTrap", 1'b0, 1'b1, 1'b0, 64'h8000_0200, 32'h13, 64'd0, 1'b1, 64'd2);
      for (int n = 0; n < 15; n++) retire("loopB", 64'h8000_0200, 32'h13, 64'(n));
      chk("loopB.15", 64'(fin[0]), 64'd0);
      retire("loopB16", 64'h8000_0200, 32'h13, 64'h1);
      chk("loopB.16", 64'(fin[0]), 64'd1);

      step("rst2", 1'b1, 1'b0, 1'b0, 64'd0, 32'h13, 64'd0, 1'b0, 64'd0);
      for (int n = 0; n < 15; n++) retire("loopC", 64'h8000_0200, 32'h13, 64'(n));
      chk("loopC.15", 64'(fin[0]), 64'd0);
      retire("loopC16", 64'h8000_0200, 32'h13, 64'h2);
      chk("loopC.16", 64'(fin[0]), 64'd1);

      // Randomized traffic
      step("rst3", 1'b1, 1'b0, 1'b0, 64'd0, 32'h13, 64'd0, 1'b0, 64'd0);
      cur = 64'h8000_0400;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 9) < 2) cur = 64'h8000_0400 + 64'(4 * $urandom_range(0, 3));
         step("rand", 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 7) == 0), cur,
              ($urandom_range(0, 39) == 0) ? 32'h0000_006f : 32'h13,
              {$urandom, $urandom}, 1'($urandom_range(0, 9) == 0),
              {$urandom, $urandom});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
